fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
Controller that sequences the program counter and instruction fetch for the small processor core. It owns the PC register, issues one fetch at a time to instruction memory over a req/ack handshake, and hands each fetched word downstream over a valid/ready handshake. It also applies branch redirects and supports run, single-step and halt control from the debug/control block.

Parameters:
ADDR_W, 8, PC / instruction address width; PC wraps modulo 2^ADDR_W
DATA_W, 16, instruction word width
RESET_VEC, 0, PC value after reset
STACK_DEPTH, 4, return-stack entries (used only with CALL_STACK_EN)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous, active-low reset
run  in  1  level; 1 = fetch continuously
step  in  1  rising edge requests one fetch/issue while run=0
halt_req  in  1  level; stop at next instruction boundary
resume  in  1  rising edge leaves HALTED
mem_req  out  1  fetch request, held until mem_ack
mem_addr  out  ADDR_W  fetch address (= pc), stable while mem_req=1
mem_ack  in  1  one-cycle acknowledge; mem_rdata is valid in the same cycle
mem_rdata  in  DATA_W  fetched word
instr_valid  out  1  instruction available downstream
instr_data  out  DATA_W  captured instruction
instr_pc  out  ADDR_W  address of instr_data
instr_ready  in  1  downstream accepts while instr_valid=1
redir_valid  in  1  sampled only on accept; next pc = redir_addr
redir_addr  in  ADDR_W  redirect target
pc  out  ADDR_W  current PC
halted  out  1  1 while in HALTED
wrapped  out  1  sticky; set when sequential increment passes 2^ADDR_W-1 -> 0
fault  out  1  sticky stack fault (0 without CALL_STACK_EN)

Behaviour:
- Reset (async, reset_n=0): pc=RESET_VEC; state=IDLE; mem_req, instr_valid, halted, wrapped and fault = 0; instr_data and instr_pc = 0; step/resume edge registers = 0; stack empty. Outputs drop immediately, aborting any outstanding fetch.
- step and resume are edge-detected with one register each: event = in & ~in_q.
- States: IDLE, FETCH, ISSUE, HALTED.
- IDLE: halt_req=1 -> HALTED (halt wins over run/step). Otherwise, if run=1 or a step event occurs -> FETCH. A step event while run=1 has no extra effect.
- FETCH: mem_req=1, mem_addr=pc. On mem_ack, capture instr_data=mem_rdata and instr_pc=pc, then go to ISSUE. mem_ack while mem_req=0 is ignored. Minimum latency from IDLE exit to instr_valid is 2 cycles with a same-cycle ack.
- ISSUE: instr_valid=1; instr_data and instr_pc are held until instr_ready=1. On accept:
  - next pc = redir_addr if redir_valid, else pc+1 truncated to ADDR_W.
  - A sequential step from all-ones sets wrapped.
  - Next state: HALTED if halt_req, else FETCH if run, else IDLE.
  - instr_valid drops the cycle after accept.
- redir_valid outside an accept cycle is ignored.
- HALTED: halted=1, no fetches, pc frozen. A resume event -> IDLE. halt_req still high on resume -> back to HALTED the next cycle.
- Halt asserted during FETCH/ISSUE does not abort; it takes effect at accept.
- Deasserting run mid-fetch completes the current instruction, then goes to IDLE.

Optional Feature:
- Macro FETCH_SEQ_CALL_STACK_EN.
- Defined: adds inputs call_valid and ret_valid, sampled on accept.
  - call: push pc+1 onto a STACK_DEPTH LIFO, then next pc = redir_addr.
  - ret: pop; next pc = popped value.
  - call and ret together: ret wins.
  - Push when full: fault=1, push dropped, jump still taken.
  - Pop when empty: fault=1, next pc = pc+1.
  - Stack cleared by reset only.
- Undefined: no stack and no call/ret ports; fault tied 0.

Test Plan:
1. Reset with RESET_VEC=0x10, run=1, memory acks in 1 cycle, instr_ready=1 -> instr_pc sequence 0x10, 0x11, 0x12; mem_addr matches; one instruction per 3 cycles.
2. run=0, two step pulses, ack delayed 3 cycles -> exactly two instructions (pc 0x00, 0x01) issued; mem_req held with stable mem_addr during the wait; returns to IDLE, pc=0x02.
3. instr_ready held 0 for 5 cycles with redir_valid=1, redir_addr=0xA0 asserted only on the accept cycle -> instr_data stable throughout; next mem_addr=0xA0.
4. pc=0xFF, ADDR_W=8, run=1 -> next fetch at 0x00, wrapped=1 and stays 1 until reset.
5. halt_req asserted during FETCH -> current instruction still issues, halted=1, no mem_req; resume pulse with halt_req=0 -> fetching restarts at pc+1.
6. reset_n pulled low mid-FETCH (mem_req=1) -> mem_req=0 immediately, pc=RESET_VEC; with FETCH_SEQ_CALL_STACK_EN, 5 calls at depth 4 -> fault=1, and 4 rets return the 4 pushed addresses.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, runs one req/ack fetch at a time and issues each word downstream.
// Define FETCH_SEQ_CALL_STACK_EN to add the call/return stack (call_valid/ret_valid, fault).
module fetch_sequencer #(
  parameter int                ADDR_W      = 8,
  parameter int                DATA_W      = 16,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
  parameter int                STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  input  logic              step,
  input  logic              halt_req,
  input  logic              resume,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_addr,
`ifdef FETCH_SEQ_CALL_STACK_EN
  input  logic              call_valid,
  input  logic              ret_valid,
`endif
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              wrapped,
  output logic              fault
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALTED} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] pc;
  } instr_t;

  state_t            state;
  instr_t            instr_q;
  logic              step_q, resume_q;
  logic              step_ev, resume_ev, accept, wrap_hit;
  logic [ADDR_W-1:0] pc_seq, pc_nxt;

  assign step_ev    = step & ~step_q;
  assign resume_ev  = resume & ~resume_q;
  assign accept     = (state == ISSUE) && instr_ready;
  assign pc_seq     = pc + 1'b1;
  assign mem_addr   = pc;
  assign instr_data = instr_q.data;
  assign instr_pc   = instr_q.pc;

`ifdef FETCH_SEQ_CALL_STACK_EN
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [STACK_DEPTH-1:0][ADDR_W-1:0] stack;
  logic [SP_W-1:0]                    sp;
  logic [IDX_W-1:0]                   push_idx, top_idx;
  logic                               push, pop, fault_hit;

  assign push_idx = IDX_W'(sp);
  assign top_idx  = IDX_W'(sp - 1'b1);

  // ret beats call; call beats a plain redirect and always jumps, even when the push is dropped
  always_comb begin
    pc_nxt    = redir_valid ? redir_addr : pc_seq;
    wrap_hit  = ~redir_valid & (&pc);
    push      = 1'b0;
    pop       = 1'b0;
    fault_hit = 1'b0;
    if (ret_valid) begin
      if (sp == '0) begin
        fault_hit = 1'b1;
        pc_nxt    = pc_seq;
        wrap_hit  = &pc;
      end else begin
        pop      = 1'b1;
        pc_nxt   = stack[top_idx];
        wrap_hit = 1'b0;
      end
    end else if (call_valid) begin
      pc_nxt   = redir_addr;
      wrap_hit = 1'b0;
      if (sp == SP_W'(STACK_DEPTH)) fault_hit = 1'b1;
      else                          push      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stack <= '0;
      sp    <= '0;
      fault <= 1'b0;
    end else if (accept) begin
      if (push) begin
        stack[push_idx] <= pc_seq;
        sp              <= sp + 1'b1;
      end
      if (pop)       sp    <= sp - 1'b1;
      if (fault_hit) fault <= 1'b1;
    end
  end
`else
  always_comb begin
    pc_nxt   = redir_valid ? redir_addr : pc_seq;
    wrap_hit = ~redir_valid & (&pc);
  end

  assign fault = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pc          <= RESET_VEC;
      mem_req     <= 1'b0;
      instr_valid <= 1'b0;
      instr_q     <= '0;
      halted      <= 1'b0;
      wrapped     <= 1'b0;
      step_q      <= 1'b0;
      resume_q    <= 1'b0;
    end else begin
      step_q   <= step;
      resume_q <= resume;
      case (state)
        IDLE: begin
          if (halt_req) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else if (run || step_ev) begin
            state   <= FETCH;
            mem_req <= 1'b1;
          end
        end
        FETCH: begin
          if (mem_ack) begin
            instr_q     <= '{data: mem_rdata, pc: pc};
            mem_req     <= 1'b0;
            instr_valid <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            pc          <= pc_nxt;
            wrapped     <= wrapped | wrap_hit;
            if (halt_req) begin
              state  <= HALTED;
              halted <= 1'b1;
            end else if (run) begin
              state   <= FETCH;
              mem_req <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        HALTED: begin
          if (resume_ev) begin
            state  <= IDLE;
            halted <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
